// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the EX/MEM stage (master) and
// the memory responder (slave).
interface dmem_responder_if;
    logic        MemRead;
    logic        MemWrite;
    logic [31:0] dir;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic        ready;
    logic        stall;
    logic        misalign;

    modport master (
        output MemRead, MemWrite, dir, dataIn,
        input  dataOut, ready, stall, misalign
    );

    modport slave (
        input  MemRead, MemWrite, dir, dataIn,
        output dataOut, ready, stall, misalign
    );
endinterface

// File: rtl/dmem_responder.sv
// Word-addressed data memory with fixed wait states, a stall back to the pipeline
// and a one-cycle ready pulse. Define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned ADDR_W      = 6,
    parameter int unsigned LATENCY     = 2
) (
    input logic             clk,
    input logic             rst,
    dmem_responder_if.slave dmem
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                rd_q;
    logic                wr_q;
    logic                mis_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [31:0]         wdata_q;
    logic [31:0]         dout_q;
    logic                ready_q;
    logic                misalign_q;
    logic [31:0]         mem_q [DEPTH_WORDS];

    logic req;
    logic mis_now;
    logic commit;
    logic mem_we;

    assign req    = dmem.MemRead | dmem.MemWrite;
    assign commit = (state_q == BUSY) && (cnt_q == '0);
    assign mem_we = commit && wr_q && !mis_q && !rst;

`ifdef DMEM_ALIGN_CHECK_EN
    assign mis_now       = (dmem.dir[1:0] != 2'b00);
    assign dmem.misalign = misalign_q;
    logic unused_bits;
    assign unused_bits = ^dmem.dir[31:ADDR_W+2];
`else
    assign mis_now       = 1'b0;
    assign dmem.misalign = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{dmem.dir[31:ADDR_W+2], dmem.dir[1:0], misalign_q};
`endif

    assign dmem.stall   = !rst && (((state_q == IDLE) && req) || (state_q == BUSY));
    assign dmem.dataOut = dout_q;
    assign dmem.ready   = ready_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dout_q     <= '0;
            ready_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    ready_q <= 1'b0;
                    if (req) begin
                        rd_q    <= dmem.MemRead;
                        wr_q    <= dmem.MemWrite;
                        mis_q   <= mis_now;
                        idx_q   <= dmem.dir[ADDR_W+1:2];
                        wdata_q <= dmem.dataIn;
                        cnt_q   <= 4'(LATENCY - 1);
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        // Read samples the old word even when a write to it commits this edge.
                        if (rd_q) dout_q <= mis_q ? '0 : mem_q[idx_q];
                        if (mis_q) misalign_q <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem_q[idx_q] <= wdata_q;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a LATENCY=2 instance for the main sequence
// and a LATENCY=1 instance for back-to-back timing.
module tb_dmem_responder;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dmem_responder_if bus2 ();
    dmem_responder_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(64), .ADDR_W(6), .LATENCY(2)) u_dut2 (
        .clk  (clk),
        .rst  (rst),
        .dmem (bus2)
    );

    dmem_responder #(.DEPTH_WORDS(64), .ADDR_W(6), .LATENCY(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .dmem (bus1)
    );

    int unsigned checks = 0;
    int unsigned errors = 0;
    logic [31:0] d;
    logic        m;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one request on the LATENCY=2 instance and hold it until ready.
    task automatic access2(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, output logic [31:0] dout, output logic mis);
        int unsigned c;
        bit got;
        bus2.MemRead  = rd;
        bus2.MemWrite = wr;
        bus2.dir      = addr;
        bus2.dataIn   = data;
        c   = 0;
        got = 1'b0;
        while (!got && c < 20) begin
            @(negedge clk);
            if (bus2.ready === 1'b1) begin
                got = 1'b1;
            end else begin
                check("stall_busy", bus2.stall, 32'd1);
                c++;
                tick();
            end
        end
        check("ready_latency", c, 32'd3);
        check("stall_at_ready", bus2.stall, 32'd0);
        dout = bus2.dataOut;
        mis  = bus2.misalign;
        tick();
        bus2.MemRead  = 1'b0;
        bus2.MemWrite = 1'b0;
        @(negedge clk);
        check("ready_one_cycle", bus2.ready, 32'd0);
        check("stall_idle", bus2.stall, 32'd0);
        check("dout_hold", bus2.dataOut, dout);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus2.MemRead  = 1'b1;
        bus2.MemWrite = 1'b0;
        bus2.dir      = 32'h0;
        bus2.dataIn   = 32'h0;
        bus1.MemRead  = 1'b0;
        bus1.MemWrite = 1'b0;
        bus1.dir      = 32'h0;
        bus1.dataIn   = 32'h0;

        tick();
        @(negedge clk);
        check("stall_forced_in_rst", bus2.stall, 32'd0);
        tick();
        rst          = 1'b0;
        bus2.MemRead = 1'b0;
        @(negedge clk);
        check("rst_dataOut", bus2.dataOut, 32'h0);
        check("rst_ready", bus2.ready, 32'd0);
        check("rst_misalign", bus2.misalign, 32'd0);
        check("rst_stall", bus2.stall, 32'd0);
        check("rst_ready_l1", bus1.ready, 32'd0);
        tick();

        access2(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, d, m);
        check("write_keeps_dout", d, 32'h0);
        access2(1'b1, 1'b0, 32'h0000_0010, 32'h0, d, m);
        check("read_0x10", d, 32'hDEAD_BEEF);

        access2(1'b0, 1'b1, 32'h0000_0010, 32'hCAFE_0001, d, m);
        access2(1'b1, 1'b0, 32'h0000_0110, 32'h0, d, m);
        check("read_wrap_0x110", d, 32'hCAFE_0001);

        access2(1'b0, 1'b1, 32'h0000_0020, 32'h1111_1111, d, m);
        access2(1'b1, 1'b1, 32'h0000_0020, 32'h2222_2222, d, m);
        check("rw_old_value", d, 32'h1111_1111);
        access2(1'b1, 1'b0, 32'h0000_0020, 32'h0, d, m);
        check("rw_new_value", d, 32'h2222_2222);

        // Known-zero word before the aborted write.
        access2(1'b0, 1'b1, 32'h0000_0030, 32'h0, d, m);
        bus2.MemWrite = 1'b1;
        bus2.dir      = 32'h0000_0030;
        bus2.dataIn   = 32'h5555_5555;
        @(negedge clk);
        check("abort_stall_idle_req", bus2.stall, 32'd1);
        tick();
        rst = 1'b1;
        @(negedge clk);
        check("abort_stall_in_rst", bus2.stall, 32'd0);
        tick();
        rst           = 1'b0;
        bus2.MemWrite = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("abort_no_ready", bus2.ready, 32'd0);
            check("abort_stall", bus2.stall, 32'd0);
            check("abort_dout_reset", bus2.dataOut, 32'h0);
            tick();
        end
        access2(1'b1, 1'b0, 32'h0000_0030, 32'h0, d, m);
        check("abort_write_discarded", d, 32'h0);

        access2(1'b0, 1'b1, 32'h0000_0012, 32'hABCD_0000, d, m);
`ifdef DMEM_ALIGN_CHECK_EN
        check("misalign_at_ready", m, 32'd1);
        access2(1'b1, 1'b0, 32'h0000_0010, 32'h0, d, m);
        check("misaligned_write_blocked", d, 32'hCAFE_0001);
        check("misalign_sticky", bus2.misalign, 32'd1);
        access2(1'b1, 1'b0, 32'h0000_0011, 32'h0, d, m);
        check("misaligned_read_zero", d, 32'h0);
`else
        check("misalign_at_ready", m, 32'd0);
        access2(1'b1, 1'b0, 32'h0000_0010, 32'h0, d, m);
        check("unaligned_write_applied", d, 32'hABCD_0000);
        check("misalign_stays_low", bus2.misalign, 32'd0);
        access2(1'b1, 1'b0, 32'h0000_0011, 32'h0, d, m);
        check("unaligned_read_serviced", d, 32'hABCD_0000);
`endif
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("misalign_cleared_by_rst", bus2.misalign, 32'd0);
        tick();

        // LATENCY=1 instance: seed a word, then two reads held back-to-back.
        bus1.MemWrite = 1'b1;
        bus1.dir      = 32'h0000_0008;
        bus1.dataIn   = 32'h0BAD_F00D;
        tick();
        tick();
        @(negedge clk);
        check("l1_write_ready", bus1.ready, 32'd1);
        tick();
        bus1.MemWrite = 1'b0;
        tick();

        bus1.MemRead = 1'b1;
        bus1.dir     = 32'h0000_0008;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            check("b2b_ready", bus1.ready, {31'b0, (c == 2 || c == 5)});
            check("b2b_stall", bus1.stall, {31'b0, !(c == 2 || c == 5)});
            if (c == 2 || c == 5) check("b2b_data", bus1.dataOut, 32'h0BAD_F00D);
            tick();
        end
        bus1.MemRead = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
